// File: rtl/bcd_pkg.sv
// -----------------------------------------------------------------------------
// bcd_pkg
// Shared types and constants for the two-digit BCD tick counter.
//   BCD_W       width of one BCD digit
//   BCD_MAX     largest legal digit value (9)
//   bcd_t       one BCD digit
//   scan_idx_t  which digit the display scanner is currently driving
// -----------------------------------------------------------------------------
package bcd_pkg;

  localparam int         BCD_W   = 4;
  localparam logic [3:0] BCD_MAX = 4'd9;

  typedef logic [BCD_W-1:0] bcd_t;

  typedef enum logic {
    SCAN_UNITS = 1'b0,
    SCAN_TENS  = 1'b1
  } scan_idx_t;

endpackage

// File: rtl/bcd_digit.sv
// -----------------------------------------------------------------------------
// bcd_digit
// One decade of a BCD up/down counter. Chain two of them by feeding the wrap
// output of the lower digit into the step input of the next one.
// Ports:
//   clk    in   system clock, rising edge
//   rst_n  in   asynchronous active-low reset, digit -> 0
//   step   in   advance the digit by one on this edge
//   up_dn  in   1 = count up, 0 = count down
//   clear  in   synchronous clear to 0, wins over step
//   digit  out  current digit value, always 0..9
//   wrap   out  combinational: this step carries/borrows into the next digit
// -----------------------------------------------------------------------------
module bcd_digit
  import bcd_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic step,
  input  logic up_dn,
  input  logic clear,
  output bcd_t digit,
  output logic wrap
);

  // Digit register. Clear wins over step; the explicit wrap values keep the
  // digit inside 0..9 so codes 10-15 are never produced.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digit <= '0;
    end else if (clear) begin
      digit <= '0;
    end else if (step) begin
      if (up_dn) begin
        digit <= (digit == BCD_MAX) ? '0 : digit + 4'd1;
      end else begin
        digit <= (digit == '0) ? BCD_MAX : digit - 4'd1;
      end
    end
  end

  // A wrap happens when stepping past the end of the decade in the current
  // direction: 9 going up, 0 going down.
  assign wrap = step & (up_dn ? (digit == BCD_MAX) : (digit == '0));

endmodule

// File: rtl/bcd_tick_counter.sv
// -----------------------------------------------------------------------------
// bcd_tick_counter
// Two-digit BCD up/down counter (00..99) stepped by a clock prescaler, with a
// time-multiplexed scanner that drives a 2-digit 7-segment display.
// Ports:
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   ena        in   block enable; low freezes every register
//   count_en   in   prescaler / count enable
//   up_dn      in   1 = up, 0 = down, sampled on the tick cycle
//   clear      in   synchronous clear of digits and prescaler (needs ena)
//   bcd_out    out  selected digit, to the BCD-to-7-segment decoder
//   digit_sel  out  one-hot digit common: [0] units, [1] tens
//   carry      out  one-cycle pulse after a 99->00 or 00->99 wrap
// Parameters:
//   PRESCALE   enabled clk cycles per count step (>= 1)
//   SCAN_DIV   enabled clk cycles per scan slot (>= 1)
// Build option:
//   BLANK_LEADING_ZERO_EN  when defined, a tens digit of 0 is blanked
//                          (digit_sel = 2'b00, bcd_out = 0 in the tens slot)
// -----------------------------------------------------------------------------
module bcd_tick_counter
  import bcd_pkg::*;
#(
  parameter int PRESCALE = 1000,
  parameter int SCAN_DIV = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       count_en,
  input  logic       up_dn,
  input  logic       clear,
  output logic [3:0] bcd_out,
  output logic [1:0] digit_sel,
  output logic       carry
);

  localparam int            PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int            SW       = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);
  localparam logic [SW-1:0] SCN_LAST = SW'(SCAN_DIV - 1);

  logic [PW-1:0] prescale;
  logic          tick;
  logic          clr_eff;
  bcd_t          units_digit;
  bcd_t          tens_digit;
  logic          units_wrap;
  logic          tens_wrap;
  logic [SW-1:0] scan_cnt;
  logic          scan_wrap;
  scan_idx_t     scan_idx;
  scan_idx_t     scan_idx_next;

  // ena gates everything, so tick and clear are both qualified with it here
  // and the digit cells never need to see ena themselves.
  assign tick    = ena & count_en & (prescale == PRE_LAST);
  assign clr_eff = ena & clear;

  // Prescaler: counts enabled cycles and wraps on the tick edge. With
  // PRESCALE = 1 PRE_LAST is 0, so every enabled cycle is a tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prescale <= '0;
    end else if (clr_eff) begin
      prescale <= '0;
    end else if (ena && count_en) begin
      prescale <= tick ? '0 : prescale + PW'(1);
    end
  end

  bcd_digit u_units (
    .clk   (clk),
    .rst_n (rst_n),
    .step  (tick),
    .up_dn (up_dn),
    .clear (clr_eff),
    .digit (units_digit),
    .wrap  (units_wrap)
  );

  bcd_digit u_tens (
    .clk   (clk),
    .rst_n (rst_n),
    .step  (units_wrap & tick),
    .up_dn (up_dn),
    .clear (clr_eff),
    .digit (tens_digit),
    .wrap  (tens_wrap)
  );

  // Carry pulse: a tens wrap is by construction a whole-counter wrap. It is
  // suppressed by clear (clear wins over the tick) and held while ena is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      carry <= 1'b0;
    end else if (ena) begin
      carry <= tens_wrap & ~clr_eff;
    end
  end

  // Scanner state register: slot counter plus the digit index it toggles.
  // Runs whenever ena is high, regardless of count_en or clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_cnt <= '0;
      scan_idx <= SCAN_UNITS;
    end else if (ena) begin
      scan_cnt <= scan_wrap ? '0 : scan_cnt + SW'(1);
      scan_idx <= scan_idx_next;
    end
  end

  assign scan_wrap = (scan_cnt == SCN_LAST);

  // Scanner next-state: flip to the other digit at the end of each slot.
  always_comb begin
    scan_idx_next = scan_idx;
    if (scan_wrap) begin
      scan_idx_next = (scan_idx == SCAN_UNITS) ? SCAN_TENS : SCAN_UNITS;
    end
  end

  // Scanner outputs: decoded only from registers (scan index and the digit
  // registers), so digit_sel is glitch-free and can never be 2'b11, and
  // bcd_out follows a digit update in the same cycle the register changes.
  always_comb begin
    digit_sel = 2'b01;
    bcd_out   = units_digit;
    if (scan_idx == SCAN_TENS) begin
`ifdef BLANK_LEADING_ZERO_EN
      if (tens_digit == '0) begin
        digit_sel = 2'b00;
        bcd_out   = '0;
      end else begin
        digit_sel = 2'b10;
        bcd_out   = tens_digit;
      end
`else
      digit_sel = 2'b10;
      bcd_out   = tens_digit;
`endif
    end
  end

endmodule

// File: tb/tb_bcd_tick_counter.sv
// -----------------------------------------------------------------------------
// tb_bcd_tick_counter
// Self-checking bench for bcd_tick_counter (PRESCALE = 4, SCAN_DIV = 2).
// A behavioural model of the count, prescaler and scanner predicts the outputs
// for each driven cycle; predictions are queued and popped after the edge.
// -----------------------------------------------------------------------------
module tb_bcd_tick_counter;

  localparam int PRESCALE = 4;
  localparam int SCAN_DIV = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic       count_en;
  logic       up_dn;
  logic       clear;
  logic [3:0] bcd_out;
  logic [1:0] digit_sel;
  logic       carry;

  typedef struct packed {
    logic [3:0] bcd;
    logic [1:0] sel;
    logic       carry;
  } exp_t;

  exp_t sb_q[$];

  int total_checks = 0;
  int bad_checks   = 0;
  int carry_seen   = 0;

  // Reference model state
  int m_count;
  int m_pre;
  int m_scan_cnt;
  int m_scan_idx;
  bit m_carry;

  bcd_tick_counter #(
    .PRESCALE (PRESCALE),
    .SCAN_DIV (SCAN_DIV)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .count_en  (count_en),
    .up_dn     (up_dn),
    .clear     (clear),
    .bcd_out   (bcd_out),
    .digit_sel (digit_sel),
    .carry     (carry)
  );

  always #5 clk = ~clk;

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total_checks++;
    if (observed !== expected) begin
      bad_checks++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
    end
  endtask

  function automatic int dutCount();
    return int'(dut.tens_digit) * 10 + int'(dut.units_digit);
  endfunction

  task automatic modelReset();
    m_count    = 0;
    m_pre      = 0;
    m_scan_cnt = 0;
    m_scan_idx = 0;
    m_carry    = 1'b0;
  endtask

  // Advance the model by one clock edge given the inputs being driven.
  task automatic modelStep(input bit e, input bit ce, input bit ud, input bit cl);
    bit tick;
    if (e) begin
      if (cl) begin
        m_count = 0;
        m_pre   = 0;
        m_carry = 1'b0;
      end else begin
        tick    = ce && (m_pre == PRESCALE - 1);
        m_carry = 1'b0;
        if (ce) m_pre = tick ? 0 : m_pre + 1;
        if (tick) begin
          if (ud) begin
            if (m_count == 99) begin m_count = 0; m_carry = 1'b1; end
            else m_count = m_count + 1;
          end else begin
            if (m_count == 0) begin m_count = 99; m_carry = 1'b1; end
            else m_count = m_count - 1;
          end
        end
      end
      if (m_scan_cnt == SCAN_DIV - 1) begin
        m_scan_cnt = 0;
        m_scan_idx = 1 - m_scan_idx;
      end else begin
        m_scan_cnt = m_scan_cnt + 1;
      end
    end
  endtask

  function automatic exp_t modelOutputs();
    exp_t x;
    x.carry = m_carry;
    if (m_scan_idx == 0) begin
      x.sel = 2'b01;
      x.bcd = 4'(m_count % 10);
    end else begin
      x.sel = 2'b10;
      x.bcd = 4'(m_count / 10);
`ifdef BLANK_LEADING_ZERO_EN
      if (m_count / 10 == 0) begin
        x.sel = 2'b00;
        x.bcd = 4'd0;
      end
`endif
    end
    return x;
  endfunction

  // Drive one cycle of inputs, queue the prediction, then compare after the edge.
  task automatic applyStimulus(input bit e, input bit ce, input bit ud, input bit cl);
    exp_t want;
    ena      = e;
    count_en = ce;
    up_dn    = ud;
    clear    = cl;
    modelStep(e, ce, ud, cl);
    sb_q.push_back(modelOutputs());
    @(posedge clk);
    #1;
    want = sb_q.pop_front();
    checkOutput("bcd_out",   bcd_out,   want.bcd);
    checkOutput("digit_sel", digit_sel, want.sel);
    checkOutput("carry",     carry,     want.carry);
    if (carry === 1'b1) carry_seen++;
  endtask

  task automatic runCycles(input int n, input bit e, input bit ce, input bit ud, input bit cl);
    for (int i = 0; i < n; i++) applyStimulus(e, ce, ud, cl);
  endtask

  initial begin
    rst_n    = 1'b0;
    ena      = 1'b0;
    count_en = 1'b0;
    up_dn    = 1'b0;
    clear    = 1'b0;
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_bcd",   bcd_out,   0);
    checkOutput("rst_sel",   digit_sel, 2'b01);
    checkOutput("rst_carry", carry,     0);
    checkOutput("rst_count", dutCount(), 0);
    rst_n = 1'b1;

    // Count up: first change on the 4th edge, 40 cycles -> 10, no carry.
    carry_seen = 0;
    runCycles(3, 1, 1, 1, 0);
    checkOutput("before_first_tick", dutCount(), 0);
    runCycles(1, 1, 1, 1, 0);
    checkOutput("first_tick", dutCount(), 1);
    runCycles(36, 1, 1, 1, 0);
    checkOutput("count_40", dutCount(), 10);
    checkOutput("carry_none_40", carry_seen, 0);

    // Up to 99, then wrap to 00 with exactly one carry.
    runCycles(356, 1, 1, 1, 0);
    checkOutput("count_99", dutCount(), 99);
    carry_seen = 0;
    runCycles(4, 1, 1, 1, 0);
    checkOutput("wrap_up_00", dutCount(), 0);
    checkOutput("wrap_up_carry_n", carry_seen, 1);

    // Down from 00 -> 99 with one carry, then 8 more cycles -> 97.
    carry_seen = 0;
    runCycles(4, 1, 1, 0, 0);
    checkOutput("wrap_dn_99", dutCount(), 99);
    runCycles(8, 1, 1, 0, 0);
    checkOutput("count_97", dutCount(), 97);
    checkOutput("wrap_dn_carry_n", carry_seen, 1);

    // Clear colliding with a tick at count 37, prescaler 3.
    runCycles(1, 1, 0, 1, 1);
    runCycles(148 + 3, 1, 1, 1, 0);
    checkOutput("pre_clear_count", dutCount(), 37);
    checkOutput("pre_clear_presc", dut.prescale, 3);
    runCycles(1, 1, 1, 1, 1);
    checkOutput("clear_count", dutCount(), 0);
    checkOutput("clear_presc", dut.prescale, 0);
    checkOutput("clear_carry", carry, 0);

    // Scanner at 42, then freeze with ena low (clear/count_en ignored).
    runCycles(168, 1, 1, 1, 0);
    checkOutput("scan_count_42", dutCount(), 42);
    runCycles(8, 1, 0, 1, 0);
    runCycles(5, 0, 1, 1, 1);
    checkOutput("frozen_count", dutCount(), 42);
    checkOutput("frozen_presc", dut.prescale, 0);

    // Asynchronous reset between edges at count 55, prescaler 2.
    runCycles(1, 1, 0, 1, 1);
    runCycles(222, 1, 1, 1, 0);
    checkOutput("pre_rst_count", dutCount(), 55);
    checkOutput("pre_rst_presc", dut.prescale, 2);
    #3;
    rst_n = 1'b0;
    #1;
    checkOutput("async_rst_bcd",   bcd_out,   0);
    checkOutput("async_rst_sel",   digit_sel, 2'b01);
    checkOutput("async_rst_carry", carry,     0);
    checkOutput("async_rst_count", dutCount(), 0);
    checkOutput("async_rst_presc", dut.prescale, 0);
    modelReset();
    #2;
    rst_n = 1'b1;

    // Count 07 and scan both slots (tens slot blanked when the option is on).
    runCycles(28, 1, 1, 1, 0);
    checkOutput("count_07", dutCount(), 7);
    runCycles(4, 1, 0, 1, 0);

    $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
    $finish;
  end

endmodule
